amber48_uart_tx: RTL and testbench

Byte-serial UART transmitter that sits on the far side of the data memory's UART MMIO port. It accepts bytes through a valid/ready handshake into a small FIFO and shifts each byte out as an 8N1 frame on `tx_o` at a fixed baud rate. The core stalls on UART stores only while the FIFO is full.

---
 rtl/amber48_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_amber48_uart_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/amber48_uart_tx.sv
// amber48_uart_tx
// Byte-serial 8N1 UART transmitter fed through a small byte FIFO.
// The bit period is DIV = CLK_HZ / BAUD clock cycles. The data memory is
// stalled on a UART store only while the FIFO is full.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   valid_i  byte offered on data_i this cycle
//   data_i   byte to transmit
//   ready_o  FIFO can accept a byte this cycle
//   tx_o     serial line, idle high, registered
//   busy_o   FIFO non-empty or frame in progress
//
// Shifter states:
//   state   | meaning
//   S_IDLE  | line idle high, waiting for a queued byte
//   S_START | start bit (low) for DIV cycles
//   S_DATA  | eight data bits, LSB first, DIV cycles each
//   S_STOP  | stop bit (high) for DIV cycles, then chain or idle
module amber48_uart_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int CW   = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int PW   = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  generate
    if (DIV < 2) begin : g_div_check
      $fatal(1, "amber48_uart_tx: CLK_HZ / BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $fatal(1, "amber48_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // FIFO
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CNTW-1:0] count;
  logic            push, pop;

  assign ready_o = (count != CNTW'(FIFO_DEPTH));
  assign push    = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: ;
      endcase
    end
  end

  // Shifter
  state_e        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic          fifo_nonempty;

  assign bit_end       = (cnt == CW'(DIV - 1));
  assign fifo_nonempty = (count != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CW'(1);
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shreg_d = mem[rptr];
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shreg[0];
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // shreg[0] is always the bit on the line; shift and present the next one
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {1'b0, shreg[7:1]};
            tx_d      = shreg[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (fifo_nonempty) begin
            // chain straight into the next start bit, no idle gap
            pop     = 1'b1;
            shreg_d = mem[rptr];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = (state != S_IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_amber48_uart_tx.sv
module tb_amber48_uart_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       ready_o, tx_o, busy_o;

  amber48_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .tx_o(tx_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rst_epoch = 0;
  int n_starts = 0;
  bit in_frame = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  int push_cyc;

  always @(posedge clk_i) cyc <= cyc + 1;
  always @(negedge rst_ni) rst_epoch++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: decodes 8N1 frames from tx_o and checks them against the scoreboard.
  initial begin
    int ep;
    logic s0, st;
    logic [7:0] b;
    forever begin
      @(negedge clk_i);
      if (rst_ni && tx_o === 1'b0) begin
        ep = rst_epoch;
        in_frame = 1;
        n_starts++;
        start_q.push_back(cyc);
        repeat (DIV / 2) @(negedge clk_i);
        s0 = tx_o;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk_i);
          b[i] = tx_o;
        end
        repeat (DIV) @(negedge clk_i);
        st = tx_o;
        if (ep == rst_epoch) begin
          check("start_bit", {31'd0, s0}, 0);
          check("stop_bit", {31'd0, st}, 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got 0x%0h, expected no frame", b);
          end else begin
            check("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
        end
        repeat (DIV / 2 - 1) @(negedge clk_i);
        in_frame = 0;
      end
    end
  end

  // Offer a byte (called at a negedge), hold until accepted; push_cyc is the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    valid_i = 1'b1;
    data_i  = b;
    n = 0;
    while (!ready_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got ready 0, expected ready 1");
      valid_i = 1'b0;
    end else begin
      exp_q.push_back(b);
      @(negedge clk_i);
      push_cyc = cyc;
      valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o || in_frame || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", {31'd0, busy_o || in_frame || exp_q.size() != 0}, 0);
  endtask

  initial begin
    int e, n, busy_drop, n0;
    bit saw_low;

    // 1. reset
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_tx", {31'd0, tx_o}, 1);
    check("reset_ready", {31'd0, ready_o}, 1);
    check("reset_busy", {31'd0, busy_o}, 0);
    rst_ni = 1'b1;
    saw_low = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) saw_low = 1;
    end
    check("idle_line_high", {31'd0, saw_low}, 0);

    // 2. single byte, latency and busy timing
    start_q.delete();
    send(8'hA5);
    e = push_cyc;
    busy_drop = -1;
    n = 0;
    while (busy_drop < 0 && n < 400) begin
      if (!busy_o) busy_drop = cyc;
      else @(negedge clk_i);
      n++;
    end
    check("busy_drop_cycle", busy_drop, e + 101);
    wait_idle();
    check("first_start_cycle", start_q.size() > 0 ? start_q[0] : -1, e + 1);

    // 3. fill: five consecutive pushes, sixth throttled
    start_q.delete();
    send(8'h01);
    e = push_cyc;
    for (int i = 2; i <= 5; i++) begin
      send(8'(i));
      check("fill_push_cycle", push_cyc, e + i - 1);
    end
    check("ready_low_when_full", {31'd0, ready_o}, 0);
    send(8'h06);
    check("sixth_push_cycle", push_cyc, e + 1 + FRAME + 1);
    wait_idle();
    check("fill_frame_count", start_q.size(), 6);
    for (int i = 1; i < 6 && i < start_q.size(); i++)
      check("back_to_back_gap", start_q[i] - start_q[i-1], FRAME);

    // 4. wrap-around at full throttle
    for (int i = 0; i < 12; i++) send(8'h10 + 8'(i));
    wait_idle();

    // random bytes with random gaps
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 250)) @(negedge clk_i);
      send(8'($urandom));
    end
    wait_idle();

    // 5. reset mid-frame with two bytes queued
    send(8'h5A);
    e = push_cyc;
    send(8'h11);
    send(8'h22);
    while (cyc < e + 45) @(negedge clk_i);
    check("bit3_before_reset", {31'd0, tx_o}, 1);
    check("busy_before_reset", {31'd0, busy_o}, 1);
    #2 rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("tx_async_reset", {31'd0, tx_o}, 1);
    check("busy_async_reset", {31'd0, busy_o}, 0);
    check("ready_async_reset", {31'd0, ready_o}, 1);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    n0 = n_starts;
    saw_low = 0;
    repeat (300) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) saw_low = 1;
    end
    check("no_frames_after_reset", n_starts, n0);
    check("line_high_after_reset", {31'd0, saw_low}, 0);
    check("busy_after_reset", {31'd0, busy_o}, 0);

    // still functional after reset
    send(8'hC3);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
